// File: rtl/mdu_iter_core.sv
// mdu_iter_core: iterative 32-bit multiply/divide unit, one radix-2 step per cycle.
//   clk, reset    : clock and synchronous active-high reset
//   start, op     : request and opcode (0 mult, 1 multu, 2 div, 3 divu)
//   a, b          : multiplicand/dividend, multiplier/divisor
//   flush         : cancel the in-flight operation
//   busy, done    : operation in progress, one-cycle completion pulse
//   hi, lo        : result registers (upper/remainder, lower/quotient)
module mdu_iter_core (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [1:0]  op_r;
   logic        sign_a, sign_b;
   logic [31:0] mcand;   // |b|: multiplicand for mult, divisor for div
   logic [63:0] acc;     // mult: product/multiplier; div: acc[31:0] dividend -> quotient
   logic [32:0] rem;     // partial remainder

   // Operand preparation: signed ops work on magnitudes.
   logic        sa, sb;
   logic [31:0] abs_a, abs_b;
   assign sa    = ~op[0] & a[31];
   assign sb    = ~op[0] & b[31];
   assign abs_a = sa ? -a : a;
   assign abs_b = sb ? -b : b;

   // Multiply step: conditional add into the upper half, then shift right.
   logic [32:0] mul_sum;
   assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);

   // Restoring divide step: shift in next dividend bit, trial-subtract divisor.
   logic [32:0] div_shift;
   logic [33:0] div_diff;
   logic        div_ok;
   assign div_shift = {rem[31:0], acc[31]};
   assign div_diff  = {1'b0, div_shift} - {2'b0, mcand};
   assign div_ok    = ~div_diff[33];

   // Sign correction. Unsigned ops never set sign_a/sign_b.
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;
   assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
   assign quo_fix  = (sign_a ^ sign_b) ? -acc[31:0] : acc[31:0];
   assign rem_fix  = sign_a ? -rem[31:0] : rem[31:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         op_r   <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mcand  <= '0;
         acc    <= '0;
         rem    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start && !flush) begin
                  op_r   <= op;
                  sign_a <= sa;
                  sign_b <= sb;
                  acc    <= {32'd0, abs_a};
                  mcand  <= abs_b;
                  rem    <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               if (flush) begin
                  busy  <= 1'b0;
                  done  <= 1'b0;
                  state <= IDLE;
               end else begin
                  if (op_r[1]) begin
                     rem       <= div_ok ? div_diff[32:0] : div_shift;
                     acc[31:0] <= {acc[30:0], div_ok};
                  end else begin
                     acc <= {mul_sum, acc[31:1]};
                  end
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'd31) state <= FIX;
               end
            end
            FIX: begin
               if (flush) begin
                  busy  <= 1'b0;
                  done  <= 1'b0;
                  state <= IDLE;
               end else begin
                  if (!op_r[1]) begin
                     hi <= prod_fix[63:32];
                     lo <= prod_fix[31:0];
                  end else if (mcand == 32'd0) begin
                     // With a zero divisor every trial succeeds, so rem ends as |a|;
                     // re-applying the dividend sign recovers the original a bits.
                     hi <= rem_fix;
                     lo <= 32'hFFFF_FFFF;
                  end else begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_iter_core.sv
// tb_mdu_iter_core: directed bench for mdu_iter_core with a cycle-level reference
// model and a per-cycle compare process, plus literal result checks.
module tb_mdu_iter_core;
   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_chk = 0;
   int n_err = 0;

   mdu_iter_core dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result of one operation, {hi, lo}.
   function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] xs, ys;
      int sx, sy, q, r;
      case (o)
         2'd0: begin
            xs = {{32{x[31]}}, x};
            ys = {{32{y[31]}}, y};
            return xs * ys;
         end
         2'd1: return {32'd0, x} * {32'd0, y};
         2'd2: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sx = x; sy = y;
            q = sx / sy; r = sx % sy;
            return {r, q};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   // Cycle-level model: an operation occupies 33 cycles of busy, then done pulses.
   logic        m_busy = 1'b0, m_done = 1'b0, cmp_en = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [1:0]  m_op;
   logic [31:0] m_a, m_b;
   int          m_left = 0;

   always @(posedge clk) begin
      if (reset) begin
         cmp_en <= 1'b1;
         m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_left <= 0;
      end else if (m_left > 0) begin
         m_done <= 1'b0;
         if (flush) begin
            m_left <= 0; m_busy <= 1'b0;
         end else if (m_left == 1) begin
            m_left <= 0; m_busy <= 1'b0; m_done <= 1'b1;
            {m_hi, m_lo} <= ref_res(m_op, m_a, m_b);
         end else begin
            m_left <= m_left - 1;
         end
      end else begin
         m_done <= 1'b0;
         if (start && !flush) begin
            m_op <= op; m_a <= a; m_b <= b;
            m_left <= 33; m_busy <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", {63'd0, busy}, {63'd0, m_busy});
         chk("done", {63'd0, done}, {63'd0, m_done});
         chk("hi", {32'd0, hi}, {32'd0, m_hi});
         chk("lo", {32'd0, lo}, {32'd0, m_lo});
      end
   end

   // Called at a negedge; issues start in that cycle, returns at the done negedge.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int nb);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      nb = 0;
      for (int i = 0; i < 100; i++) begin
         if (done) break;
         if (busy) nb++;
         @(negedge clk);
      end
      chk("done_seen", {63'd0, done}, 64'd1);
   endtask

   int nb, ndone;

   initial begin
      reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);

      chk("ref_pin_mult", ref_res(2'd0, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
      chk("ref_pin_div", ref_res(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
      chk("multu_busy_len", nb, 64'd33);
      chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_op(2'd0, 32'hFFFF_FFFD, 32'd7, nb);
      chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, nb);
      chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(2'd3, 32'd100, 32'd0, nb);
      chk("divu_by0", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb);
      chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
      run_op(2'd2, 32'hFFFF_FFFB, 32'd0, nb);
      chk("div_by0", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);
      run_op(2'd2, 32'd7, 32'hFFFF_FFFE, nb);
      chk("div_negb", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
      run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, nb);
      run_op(2'd3, 32'hDEAD_BEEF, 32'd1000, nb);

      // Start while busy is ignored.
      start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      start = 1'b1; op = 2'd3; a = 32'd9; b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 80; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("ignore_start_ndone", ndone, 64'd1);
      chk("ignore_start_res", {hi, lo}, 64'd15);

      run_op(2'd3, 32'h0000_2211, 32'h100, nb);
      chk("preset_1122", {hi, lo}, {32'h11, 32'h22});

      // Flush mid-divide.
      @(negedge clk);
      start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", {63'd0, busy}, 64'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("flush_ndone", ndone, 64'd0);
      chk("flush_hilo", {hi, lo}, {32'h11, 32'h22});

      // Flush together with start in IDLE: nothing starts.
      start = 1'b1; flush = 1'b1; op = 2'd1; a = 32'd2; b = 32'd2;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_start_busy", {63'd0, busy}, 64'd0);
      repeat (2) @(negedge clk);

      // Reset mid-multiply, then a clean operation.
      start = 1'b1; op = 2'd0; a = 32'd5; b = 32'hFFFF_FFFA;
      @(negedge clk);
      start = 1'b0;
      repeat (18) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      chk("midrst_hilo", {hi, lo}, 64'd0);
      run_op(2'd0, 32'h0001_0000, 32'h0001_0000, nb);
      chk("after_rst_busy_len", nb, 64'd33);
      chk("after_rst_res", {hi, lo}, 64'h0000_0001_0000_0000);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
